// File: rtl/single_clk_fifo.sv
// Single-clock FIFO with registered read data. Occupancy, flags, pointers and
// the full storage array are exposed so internal state can be observed directly.
module single_clk_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr,
  input  logic                        rd,
  input  logic [DATA_WIDTH-1:0]       din,
  output logic [DATA_WIDTH-1:0]       dout,
  output logic                        empty,
  output logic                        full,
  output logic [ADDR_WIDTH:0]         fifo_cnt,
  output logic [DEPTH*DATA_WIDTH-1:0] fifo_mem,
  output logic [ADDR_WIDTH-1:0]       rd_ptr,
  output logic [ADDR_WIDTH-1:0]       wr_ptr
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  wr_en, rd_en;

  // Handshake: wr/rd are requests sampled at the rising edge; a write is
  // accepted only while !full and a read only while !empty, judged on the
  // flags before the edge. Rejected requests have no effect at all.
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (ADDR_WIDTH+1)'(DEPTH));
  assign wr_en = wr & ~full;
  assign rd_en = rd & ~empty;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      dout_d   = mem_q[rd_ptr_q];
    end
    case ({wr_en, rd_en})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage is cleared on reset too, so fifo_mem reads all-zero afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      dout_q   <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      if (wr_en) mem_q[wr_ptr_q] <= din;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign fifo_mem[g*DATA_WIDTH +: DATA_WIDTH] = mem_q[g];
  end

  assign dout     = dout_q;
  assign fifo_cnt = cnt_q;
  assign rd_ptr   = rd_ptr_q;
  assign wr_ptr   = wr_ptr_q;

endmodule

// File: tb/tb_single_clk_fifo.sv
// Directed bench for single_clk_fifo: read data is checked by a scoreboard
// monitor, internal state by direct checks against hand-computed values.
module tb_single_clk_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  wr  = 1'b0;
  logic                  rd  = 1'b0;
  logic [DW-1:0]         din = '0;
  logic [DW-1:0]         dout;
  logic                  empty, full;
  logic [AW:0]           fifo_cnt;
  logic [DEPTH*DW-1:0]   fifo_mem;
  logic [AW-1:0]         rd_ptr, wr_ptr;

  single_clk_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .wr(wr), .rd(rd), .din(din), .dout(dout),
    .empty(empty), .full(full), .fifo_cnt(fifo_cnt), .fifo_mem(fifo_mem),
    .rd_ptr(rd_ptr), .wr_ptr(wr_ptr)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard
  logic [DW-1:0] exp_q[$];
  int            due_q[$];
  int            n_tests = 0;
  int            n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    while (due_q.size() > 0 && due_q[0] <= cyc) begin
      void'(due_q.pop_front());
      check("dout_sb", 32'(dout), 32'(exp_q.pop_front()));
    end
  end

  // drivers: called at posedge+1, return at the next posedge+1
  task automatic cycle(input logic w, input logic r, input logic [DW-1:0] d,
                       input logic exp_rd, input logic [DW-1:0] exp_d);
    wr = w; rd = r; din = d;
    if (exp_rd) begin
      due_q.push_back(cyc + 1);
      exp_q.push_back(exp_d);
    end
    @(posedge clk); #1;
    wr = 1'b0; rd = 1'b0;
  endtask

  task automatic write(input logic [DW-1:0] d);
    cycle(1'b1, 1'b0, d, 1'b0, '0);
  endtask

  task automatic read(input logic [DW-1:0] e);
    cycle(1'b0, 1'b1, '0, 1'b1, e);
  endtask

  task automatic check_state(input int cnt, input logic e, input logic f, input int rp, input int wp);
    check("fifo_cnt", 32'(fifo_cnt), 32'(cnt));
    check("empty", 32'(empty), 32'(e));
    check("full", 32'(full), 32'(f));
    check("rd_ptr", 32'(rd_ptr), 32'(rp));
    check("wr_ptr", 32'(wr_ptr), 32'(wp));
  endtask

  task automatic check_mem(input int idx, input logic [DW-1:0] e);
    check($sformatf("mem[%0d]", idx), 32'(fifo_mem[idx*DW +: DW]), 32'(e));
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    check_state(0, 1'b1, 1'b0, 0, 0);
    check("dout_rst", 32'(dout), 32'h0);
    for (int i = 0; i < DEPTH; i++) check_mem(i, 8'h00);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    // power-on reset
    #12;
    check_state(0, 1'b1, 1'b0, 0, 0);
    check("dout_por", 32'(dout), 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;

    // reset mid-run after 3 writes and one read
    write(8'hA1); write(8'hA2); write(8'hA3);
    check_state(3, 1'b0, 1'b0, 0, 3);
    read(8'hA1);
    check_state(2, 1'b0, 1'b0, 1, 3);
    do_reset();

    // fill, then overflow attempt
    for (int i = 0; i < DEPTH; i++) write(8'(8'h10 + i));
    check_state(16, 1'b0, 1'b1, 0, 0);
    for (int i = 0; i < DEPTH; i++) check_mem(i, 8'(8'h10 + i));
    write(8'hAA);
    check_state(16, 1'b0, 1'b1, 0, 0);
    check_mem(0, 8'h10);
    check_mem(15, 8'h1F);

    // drain, then underflow attempt
    for (int i = 0; i < DEPTH; i++) read(8'(8'h10 + i));
    check_state(0, 1'b1, 1'b0, 0, 0);
    cycle(1'b0, 1'b1, '0, 1'b0, '0);
    check("dout_underflow", 32'(dout), 32'h1F);
    check_state(0, 1'b1, 1'b0, 0, 0);

    // simultaneous rd/wr while empty: only the write lands
    cycle(1'b1, 1'b1, 8'hC0, 1'b0, '0);
    check_state(1, 1'b0, 1'b0, 0, 1);
    check("dout_sim_empty", 32'(dout), 32'h1F);
    check_mem(0, 8'hC0);

    // simultaneous rd/wr at cnt=5: both land
    write(8'hC1); write(8'hC2); write(8'hC3); write(8'hC4);
    check_state(5, 1'b0, 1'b0, 0, 5);
    cycle(1'b1, 1'b1, 8'hC5, 1'b1, 8'hC0);
    check_state(5, 1'b0, 1'b0, 1, 6);
    check_mem(5, 8'hC5);

    // simultaneous rd/wr while full: only the read lands
    for (int i = 0; i < 11; i++) write(8'(8'hD0 + i));
    check_state(16, 1'b0, 1'b1, 1, 1);
    check_mem(0, 8'hDA);
    cycle(1'b1, 1'b1, 8'hEE, 1'b1, 8'hC1);
    check_state(15, 1'b0, 1'b0, 2, 1);
    check_mem(1, 8'hC1);

    // pointer wrap-around
    do_reset();
    for (int i = 0; i < 10; i++) write(8'(8'h20 + i));
    check_state(10, 1'b0, 1'b0, 0, 10);
    for (int i = 0; i < 10; i++) read(8'(8'h20 + i));
    check_state(0, 1'b1, 1'b0, 10, 10);
    for (int i = 0; i < 10; i++) write(8'(8'h30 + i));
    check_state(10, 1'b0, 1'b0, 10, 4);
    check_mem(15, 8'h35);
    check_mem(0, 8'h36);
    for (int i = 0; i < 10; i++) read(8'(8'h30 + i));
    check_state(0, 1'b1, 1'b0, 4, 4);

    // idle at cnt=3
    write(8'h41); write(8'h42); write(8'h43);
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, 1'b0, '0, 1'b0, '0);
      check_state(3, 1'b0, 1'b0, 4, 7);
      check("dout_idle", 32'(dout), 32'h39);
      check_mem(4, 8'h41);
      check_mem(6, 8'h43);
    end

    @(negedge clk); #1;
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
